seq_multiplier: RTL and testbench

Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with a load/busy/done handshake.
- Supports unsigned and two's-complement signed operands, selected per operation.
- Processes one multiplier bit per clock.
- Replaces the combinational multiply tree wherever area matters more than latency.
- Sits behind a controller that issues load and waits on done.

---
 rtl/seq_multiplier.sv | 121 ++++++++++++
 tb/tb_seq_multiplier.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operation.
// One multiplier bit is retired per clock; load/busy/done handshake toward a controller.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier is zero.
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   P,
  output logic                 done,
  output logic                 busy
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      acc_q;
  logic [PW-1:0]      mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;

  logic [WIDTH-1:0]   a_mag_c;
  logic [WIDTH-1:0]   b_mag_c;
  logic [PW-1:0]      acc_sum_c;
  logic [WIDTH-1:0]   mplier_shift_c;
  logic [PW-1:0]      prod_c;
  logic               last_c;

  // Operand magnitudes; -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits unsigned in WIDTH bits
  always_comb begin
    a_mag_c = A;
    b_mag_c = B;
    if (signed_mode && A[WIDTH-1]) a_mag_c = ~A + WIDTH'(1);
    if (signed_mode && B[WIDTH-1]) b_mag_c = ~B + WIDTH'(1);
  end

  // One shift-add step, the completion test and the sign-corrected final product
  always_comb begin
    acc_sum_c      = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_shift_c = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_c         = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shift_c == '0);
`else
    last_c         = (cnt_q == CNT_W'(WIDTH - 1));
`endif
    prod_c         = neg_q ? (~acc_sum_c + PW'(1)) : acc_sum_c;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load)   state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    if (load)   state_d = RUN;
      default:             state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: capture on accepted load, iterate in RUN, publish P only on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      P        <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load) begin
            acc_q    <= '0;
            mcand_q  <= PW'(a_mag_c);
            mplier_q <= b_mag_c;
            cnt_q    <= '0;
            neg_q    <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          end
        end
        RUN: begin
          acc_q    <= acc_sum_c;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shift_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_c) P <= prod_c;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags registered from the next state so they track state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8): vector table plus handshake corner sequences.
module tb_seq_multiplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        signed_mode;
  logic [15:0] P;
  logic        done;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .load(load), .A(A), .B(B),
    .signed_mode(signed_mode), .P(P), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected latency from the multiplier magnitude
  function automatic int exp_lat(input logic [7:0] b, input logic sm);
    logic [7:0] m;
    int l;
    m = (sm && b[7]) ? (~b + 8'd1) : b;
    l = 1;
    for (int i = 0; i < 8; i++) if (m[i]) l = i + 1;
    return EARLY ? l : 8;
  endfunction

  // Wait (bounded) for done; flags any cycle where busy is wrong while waiting
  task automatic wait_done(inout int cyc, inout bit flags_ok);
    while (!done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (busy && done) flags_ok = 1'b0;
      if (!done && !busy) flags_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] exp_p);
    int cyc;
    bit ok;
    @(negedge clk);
    A = a; B = b; signed_mode = sm; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    cyc = 0;
    ok = 1'b1;
    check({name, "_start"}, {30'd0, busy, done}, 32'h2);
    wait_done(cyc, ok);
    check({name, "_lat"}, cyc, exp_lat(b, sm));
    check({name, "_flags"}, {31'd0, ok}, 32'h1);
    check({name, "_p"}, P, exp_p);
  endtask

  initial begin
    int cyc;
    int k;
    bit ok;

    vecs[0]  = '{8'd13,  8'd11,  1'b0, 16'h008F};
    vecs[1]  = '{8'hFD,  8'h05,  1'b1, 16'hFFF1};
    vecs[2]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[3]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
    vecs[4]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
    vecs[5]  = '{8'h00,  8'hAB,  1'b0, 16'h0000};
    vecs[6]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[7]  = '{8'd200, 8'd1,   1'b0, 16'h00C8};
    vecs[8]  = '{8'd2,   8'h80,  1'b0, 16'h0100};
    vecs[9]  = '{8'd7,   8'hFF,  1'b1, 16'hFFF9};
    vecs[10] = '{8'h80,  8'h80,  1'b0, 16'h4000};
    vecs[11] = '{8'd200, 8'd0,   1'b0, 16'h0000};

    rst = 1'b1; load = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {15'd0, P, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned op, then result must hold while idle
    run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (!(done && !busy && P == 16'h008F)) ok = 1'b0;
    end
    check("hold_20", {31'd0, ok}, 32'h1);

    // Vector table
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].p);

    // Load pulse during RUN must be ignored
    k = (exp_lat(8'd3, 1'b0) > 3) ? 3 : 1;
    @(negedge clk);
    A = 8'd2; B = 8'd3; signed_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    cyc = 0;
    ok = 1'b1;
    for (int i = 0; i < k - 1; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy || done) ok = 1'b0;
    end
    @(negedge clk);
    A = 8'd7; B = 8'd7; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    cyc++;
    wait_done(cyc, ok);
    check("intr_lat", cyc, exp_lat(8'd3, 1'b0));
    check("intr_flags", {31'd0, ok}, 32'h1);
    check("intr_p", P, 16'h0006);
    repeat (5) @(posedge clk);
    #1;
    check("intr_after", {15'd0, P, busy, done}, {15'd0, 16'h0006, 1'b0, 1'b1});

    // Back-to-back with load held high
    @(negedge clk);
    A = 8'd5; B = 8'd6; signed_mode = 1'b0; load = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_restart%0d", r), {30'd0, busy, done}, 32'h2);
      cyc = 0;
      ok = 1'b1;
      wait_done(cyc, ok);
      check($sformatf("b2b_lat%0d", r), cyc, exp_lat(8'd6, 1'b0));
      check($sformatf("b2b_p%0d", r), P, 16'h001E);
    end
    @(negedge clk);
    load = 1'b0;
    @(posedge clk); #1;
    check("b2b_hold", {15'd0, P, busy, done}, {15'd0, 16'h001E, 1'b0, 1'b1});

    // Reset mid-operation
    run_op("pre_rst", 8'd13, 8'd11, 1'b0, 16'h008F);
    @(negedge clk);
    A = 8'd3; B = 8'hC5; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midop_rst", {15'd0, P, busy, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {15'd0, P, busy, done}, 32'h0);
    run_op("post_rst", 8'd13, 8'd11, 1'b0, 16'h008F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
